ex_operand_stage: RTL and testbench

ID/EX pipeline register with operand forwarding and load-use hazard detection, sitting directly upstream of the ALU. It captures decoded operands and control from the decode stage and resolves RAW hazards against the EX and MEM stages. It drives the ALU's `a`, `b` and `aluc` from registers, so the ALU sees stable operands for a full cycle. It also raises a stall to decode when a load result is not yet available.

---
 rtl/ex_operand_stage_if.sv | 53 +++++
 rtl/ex_operand_stage.sv | 92 +++++++++
 tb/tb_ex_operand_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Decode-to-EX bundle: decoded operands and control in, forwarding sources in,
// registered ALU operands, EX control and hazard status out.
interface ex_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rn;
    logic [WIDTH-1:0] id_qa;
    logic [WIDTH-1:0] id_qb;
    logic [WIDTH-1:0] id_imm;
    logic [4:0]       id_sa;
    logic [3:0]       id_aluc;
    logic             id_aluimm;
    logic             id_shift;
    logic             id_uses_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic             flush;
    logic [WIDTH-1:0] ex_r;
    logic [4:0]       mem_wn;
    logic             mem_wreg;
    logic [WIDTH-1:0] mem_wdata;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_aluc;
    logic             ex_valid;
    logic             ex_wreg;
    logic             ex_m2reg;
    logic [4:0]       ex_wn;
    logic [WIDTH-1:0] ex_sdata;
    logic             stall;
    logic [CNTW-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rn, id_qa, id_qb, id_imm, id_sa,
               id_aluc, id_aluimm, id_shift, id_uses_rt, id_wreg, id_m2reg,
               flush, ex_r, mem_wn, mem_wreg, mem_wdata,
        input  alu_a, alu_b, alu_aluc, ex_valid, ex_wreg, ex_m2reg, ex_wn,
               ex_sdata, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rn, id_qa, id_qb, id_imm, id_sa,
               id_aluc, id_aluimm, id_shift, id_uses_rt, id_wreg, id_m2reg,
               flush, ex_r, mem_wn, mem_wreg, mem_wdata,
        output alu_a, alu_b, alu_aluc, ex_valid, ex_wreg, ex_m2reg, ex_wn,
               ex_sdata, stall, stall_cnt
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM operand forwarding, load-use stall
// detection and a saturating stall-cycle counter.
module ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    ex_operand_stage_if.slave bus
);
    logic [WIDTH-1:0] alu_a_q, alu_b_q, ex_sdata_q;
    logic [3:0]       alu_aluc_q;
    logic             ex_valid_q, ex_wreg_q, ex_m2reg_q;
    logic [4:0]       ex_wn_q;
    logic [CNTW-1:0]  stall_cnt_q;

    logic             ex_fwd_ok, mem_fwd_ok;
    logic             fa_ex, fa_mem, fb_ex, fb_mem;
    logic [WIDTH-1:0] fa, fb, opa, opb;
    logic             stall, bubble;

    always_comb begin
        // A load in EX has no result yet, so it is never an EX forward source.
        ex_fwd_ok  = ex_valid_q & ex_wreg_q & ~ex_m2reg_q & (ex_wn_q != 5'd0);
        mem_fwd_ok = bus.mem_wreg & (bus.mem_wn != 5'd0);

        fa_ex  = ex_fwd_ok  & (ex_wn_q    == bus.id_rs);
        fa_mem = mem_fwd_ok & (bus.mem_wn == bus.id_rs);
        fb_ex  = ex_fwd_ok  & (ex_wn_q    == bus.id_rt);
        fb_mem = mem_fwd_ok & (bus.mem_wn == bus.id_rt);

        fa = fa_ex ? bus.ex_r : (fa_mem ? bus.mem_wdata : bus.id_qa);
        fb = fb_ex ? bus.ex_r : (fb_mem ? bus.mem_wdata : bus.id_qb);

        opa = bus.id_shift  ? WIDTH'(bus.id_sa) : fa;
        opb = bus.id_aluimm ? bus.id_imm        : fb;

        stall = bus.id_valid & ex_valid_q & ex_m2reg_q & ex_wreg_q &
                (ex_wn_q != 5'd0) &
                ((ex_wn_q == bus.id_rs) | (bus.id_uses_rt & (ex_wn_q == bus.id_rt)));

        bubble = bus.flush | stall | ~bus.id_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_aluc_q  <= '0;
            ex_valid_q  <= 1'b0;
            ex_wreg_q   <= 1'b0;
            ex_m2reg_q  <= 1'b0;
            ex_wn_q     <= '0;
            ex_sdata_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != {CNTW{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNTW'(1);

            if (bubble) begin
                alu_a_q    <= '0;
                alu_b_q    <= '0;
                alu_aluc_q <= '0;
                ex_valid_q <= 1'b0;
                ex_wreg_q  <= 1'b0;
                ex_m2reg_q <= 1'b0;
                ex_wn_q    <= '0;
                ex_sdata_q <= '0;
            end else begin
                alu_a_q    <= opa;
                alu_b_q    <= opb;
                alu_aluc_q <= bus.id_aluc;
                ex_valid_q <= 1'b1;
                ex_wreg_q  <= bus.id_wreg;
                ex_m2reg_q <= bus.id_m2reg;
                ex_wn_q    <= bus.id_rn;
                ex_sdata_q <= fb;
            end
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_aluc  = alu_aluc_q;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_wreg   = ex_wreg_q;
    assign bus.ex_m2reg  = ex_m2reg_q;
    assign bus.ex_wn     = ex_wn_q;
    assign bus.ex_sdata  = ex_sdata_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; a second narrow-counter instance shares
// the same stimulus so counter saturation is reachable in a short run.
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.WIDTH(32), .CNTW(16)) dif ();
    ex_operand_stage_if #(.WIDTH(32), .CNTW(4))  sif ();

    ex_operand_stage #(.WIDTH(32), .CNTW(16)) u_dut (.clk(clk), .rst(rst), .bus(dif.slave));
    ex_operand_stage #(.WIDTH(32), .CNTW(4))  u_sat (.clk(clk), .rst(rst), .bus(sif.slave));

    assign sif.id_valid   = dif.id_valid;
    assign sif.id_rs      = dif.id_rs;
    assign sif.id_rt      = dif.id_rt;
    assign sif.id_rn      = dif.id_rn;
    assign sif.id_qa      = dif.id_qa;
    assign sif.id_qb      = dif.id_qb;
    assign sif.id_imm     = dif.id_imm;
    assign sif.id_sa      = dif.id_sa;
    assign sif.id_aluc    = dif.id_aluc;
    assign sif.id_aluimm  = dif.id_aluimm;
    assign sif.id_shift   = dif.id_shift;
    assign sif.id_uses_rt = dif.id_uses_rt;
    assign sif.id_wreg    = dif.id_wreg;
    assign sif.id_m2reg   = dif.id_m2reg;
    assign sif.flush      = dif.flush;
    assign sif.ex_r       = dif.ex_r;
    assign sif.mem_wn     = dif.mem_wn;
    assign sif.mem_wreg   = dif.mem_wreg;
    assign sif.mem_wdata  = dif.mem_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dif.id_valid = 0; dif.id_rs = 0; dif.id_rt = 0; dif.id_rn = 0;
        dif.id_qa = 0; dif.id_qb = 0; dif.id_imm = 0; dif.id_sa = 0;
        dif.id_aluc = 0; dif.id_aluimm = 0; dif.id_shift = 0; dif.id_uses_rt = 0;
        dif.id_wreg = 0; dif.id_m2reg = 0; dif.flush = 0;
        dif.ex_r = 0; dif.mem_wn = 0; dif.mem_wreg = 0; dif.mem_wdata = 0;
    endtask

    // Drive one decode instruction; forwarding sources are left untouched.
    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn,
                         input logic [31:0] qa, input logic [31:0] qb, input logic [3:0] aluc,
                         input logic uses_rt, input logic wreg, input logic m2reg);
        dif.id_valid = 1; dif.id_rs = rs; dif.id_rt = rt; dif.id_rn = rn;
        dif.id_qa = qa; dif.id_qb = qb; dif.id_aluc = aluc;
        dif.id_uses_rt = uses_rt; dif.id_wreg = wreg; dif.id_m2reg = m2reg;
        dif.id_aluimm = 0; dif.id_shift = 0; dif.id_imm = 0; dif.id_sa = 0; dif.flush = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_a", dif.alu_a, 0);
        chk("rst_ex_valid", dif.ex_valid, 0);
        chk("rst_stall_cnt", dif.stall_cnt, 0);
        @(negedge clk) rst = 0;

        // id_valid low -> bubble
        dif.id_qa = 32'h33;
        step();
        chk("novalid_ex_valid", dif.ex_valid, 0);
        chk("novalid_alu_a", dif.alu_a, 0);

        // plain capture
        instr(5'd0, 5'd0, 5'd1, 32'd12, 32'd8, 4'b1000, 1'b1, 1'b1, 1'b0);
        step();
        chk("cap_alu_a", dif.alu_a, 12);
        chk("cap_alu_b", dif.alu_b, 8);
        chk("cap_aluc", dif.alu_aluc, 4'b1000);
        chk("cap_ex_valid", dif.ex_valid, 1);
        chk("cap_ex_wn", dif.ex_wn, 1);
        chk("cap_sdata", dif.ex_sdata, 8);

        // ALU writing r5 enters EX
        instr(5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 4'd1, 1'b0, 1'b1, 1'b0);
        step();
        // EX forward of rs; this one also writes r5
        instr(5'd5, 5'd0, 5'd5, 32'd0, 32'd0, 4'd2, 1'b0, 1'b1, 1'b0);
        dif.ex_r = 32'h55;
        step();
        chk("exfwd_alu_a", dif.alu_a, 32'h55);
        // EX and MEM both write r5: EX wins
        instr(5'd5, 5'd0, 5'd7, 32'd0, 32'd0, 4'd2, 1'b0, 1'b1, 1'b0);
        dif.mem_wn = 5'd5; dif.mem_wreg = 1; dif.mem_wdata = 32'h77;
        step();
        chk("exprio_alu_a", dif.alu_a, 32'h55);
        // MEM-only forward on rs, EX forward on rt into sdata, b from immediate
        instr(5'd5, 5'd7, 5'd3, 32'd0, 32'd0, 4'd3, 1'b1, 1'b1, 1'b1);
        dif.ex_r = 32'h33; dif.id_aluimm = 1; dif.id_imm = 32'hABC;
        step();
        chk("memfwd_alu_a", dif.alu_a, 32'h77);
        chk("imm_alu_b", dif.alu_b, 32'hABC);
        chk("exfwd_sdata", dif.ex_sdata, 32'h33);
        chk("load_ex_m2reg", dif.ex_m2reg, 1);

        // load-use on rt -> one bubble
        instr(5'd0, 5'd3, 5'd3, 32'd0, 32'd0, 4'd4, 1'b1, 1'b1, 1'b1);
        dif.mem_wreg = 0; dif.mem_wn = 0; dif.mem_wdata = 0;
        #1;
        chk("lu_stall", dif.stall, 1);
        step();
        chk("lu_bubble_valid", dif.ex_valid, 0);
        chk("lu_bubble_alu_b", dif.alu_b, 0);
        chk("lu_bubble_m2reg", dif.ex_m2reg, 0);
        chk("lu_stall_cnt", dif.stall_cnt, 1);
        chk("lu_stall_clear", dif.stall, 0);
        dif.mem_wn = 5'd3; dif.mem_wreg = 1; dif.mem_wdata = 32'h1234;
        step();
        chk("lu_memfwd_alu_b", dif.alu_b, 32'h1234);
        chk("lu_ex_valid", dif.ex_valid, 1);
        chk("lu_stall_cnt_hold", dif.stall_cnt, 1);

        // load r3 in EX, rt=3 but rt unused -> no stall; load not EX-forwarded
        instr(5'd0, 5'd3, 5'd0, 32'd0, 32'h44, 4'd5, 1'b0, 1'b1, 1'b0);
        dif.mem_wreg = 0; dif.mem_wn = 0; dif.mem_wdata = 0;
        dif.id_shift = 1; dif.id_sa = 5'd17; dif.ex_r = 32'hDEAD;
        #1;
        chk("nouse_rt_stall", dif.stall, 0);
        step();
        chk("shift_alu_a", dif.alu_a, 17);
        chk("noldfwd_alu_b", dif.alu_b, 32'h44);

        // EX writes r0: never forwarded
        instr(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 4'd6, 1'b1, 1'b1, 1'b1);
        dif.ex_r = 32'h99;
        #1;
        chk("r0_stall", dif.stall, 0);
        step();
        chk("r0_alu_a", dif.alu_a, 0);
        // load to r0 in EX: no stall
        instr(5'd0, 5'd0, 5'd4, 32'd1, 32'd0, 4'd6, 1'b1, 1'b1, 1'b0);
        #1;
        chk("r0_load_stall", dif.stall, 0);
        step();

        // flush
        instr(5'd0, 5'd0, 5'd6, 32'h11, 32'd0, 4'd7, 1'b0, 1'b1, 1'b0);
        dif.flush = 1;
        step();
        chk("flush_ex_valid", dif.ex_valid, 0);
        chk("flush_ex_wreg", dif.ex_wreg, 0);
        chk("flush_alu_a", dif.alu_a, 0);

        // flush together with stall: bubble and count
        instr(5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 4'd1, 1'b0, 1'b1, 1'b1);
        step();
        instr(5'd2, 5'd0, 5'd1, 32'd0, 32'd0, 4'd1, 1'b0, 1'b1, 1'b0);
        dif.flush = 1;
        #1;
        chk("flstall_stall", dif.stall, 1);
        step();
        chk("flstall_valid", dif.ex_valid, 0);
        chk("flstall_cnt", dif.stall_cnt, 2);

        // async reset mid-cycle
        instr(5'd0, 5'd0, 5'd1, 32'h5A, 32'h5B, 4'd9, 1'b0, 1'b1, 1'b0);
        step();
        chk("pre_rst_alu_a", dif.alu_a, 32'h5A);
        #2 rst = 1;
        #1;
        chk("arst_alu_a", dif.alu_a, 0);
        chk("arst_ex_valid", dif.ex_valid, 0);
        chk("arst_aluc", dif.alu_aluc, 0);
        chk("arst_stall_cnt", dif.stall_cnt, 0);
        @(negedge clk) rst = 0;
        step();
        chk("post_rst_alu_a", dif.alu_a, 32'h5A);

        // repeated load-use pairs: saturation on the 4-bit counter
        for (int i = 1; i <= 20; i++) begin
            instr(5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1);
            step();
            instr(5'd3, 5'd0, 5'd1, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
            step();
            if (i == 14) chk("sat_cnt_14", sif.stall_cnt, 14);
            if (i == 15) chk("sat_cnt_15", sif.stall_cnt, 15);
        end
        chk("sat_cnt_hold", sif.stall_cnt, 15);
        chk("wide_cnt_20", dif.stall_cnt, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
